// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and helpers for the memory port arbiter
package mem_arb_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;
    localparam logic [1:0] LEN_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    // A request is rejected before touching memory when its length is
    // reserved or its address is not naturally aligned for that length.
    function automatic logic is_illegal(input logic [1:0] len, input logic [1:0] addr_lo);
        case (len)
            LEN_HALF: return addr_lo[0];
            LEN_WORD: return |addr_lo;
            LEN_RSVD: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin picker
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req[1:0]  : request vector (bit 0 core, bit 1 DMA)
//   advance   : commit the current pick as the new last grant
//   grant     : index of the picked requester (combinational)
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);

    logic last_grant;

    always_comb begin
        grant = OWN_CORE;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = OWN_DMA;
        end
    end

    // Resetting to DMA makes the core win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_DMA;
        end else if (advance) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - core/DMA arbiter and sequencer for the shared memory port
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   core_* / dma_*  req side      : req, we, addr, wdata, len from each requester
//   core_* / dma_*  resp side     : rdata (held), done pulse, err qualifier
//   mem_rd_en, mem_wr_en          : strobes, high for the whole ACCESS state
//   mem_address, mem_wdata, mem_len : latched transaction fields
//   mem_rdata, mem_ack            : memory return path
//   busy, owner                   : not idle / current owner (0 core, 1 DMA)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [1:0]        core_len,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    output logic              core_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [1:0]        dma_len,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              dma_err,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_len,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              owner
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state;
    state_t            state_next;
    logic              we_q;
    logic [7:0]        cnt;
    logic [7:0]        cnt_inc;
    logic              grant;
    logic              any_req;
    logic              grant_fire;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_len;
    logic              sel_illegal;
    logic              next_we;
    logic              go_resp;
    logic              resp_owner;
    logic              resp_err;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({dma_req, core_req}),
        .advance (grant_fire),
        .grant   (grant)
    );

    always_comb begin
        any_req     = core_req | dma_req;
        grant_fire  = (state == IDLE) && any_req;
        sel_we      = grant ? dma_we    : core_we;
        sel_addr    = grant ? dma_addr  : core_addr;
        sel_wdata   = grant ? dma_wdata : core_wdata;
        sel_len     = grant ? dma_len   : core_len;
        sel_illegal = is_illegal(sel_len, sel_addr[1:0]);
        next_we     = grant_fire ? sel_we : we_q;
        // Saturating so a large TIMEOUT can never be skipped by a wrap.
        cnt_inc     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end

    // Next-state logic; also decides which requester gets the response
    // and whether it is an error.
    always_comb begin
        state_next = state;
        resp_owner = owner;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    resp_owner = grant;
                    if (sel_illegal) begin
                        state_next = RESP;
                        resp_err   = 1'b1;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // ack has priority over a timeout in the same cycle
                if (mem_ack) begin
                    state_next = RESP;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    state_next = RESP;
                    resp_err   = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        go_resp = (state != RESP) && (state_next == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWN_CORE;
            we_q        <= 1'b0;
            cnt         <= 8'd0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_len     <= LEN_BYTE;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            busy        <= 1'b0;
            core_done   <= 1'b0;
            core_err    <= 1'b0;
            dma_done    <= 1'b0;
            dma_err     <= 1'b0;
            core_rdata  <= '0;
            dma_rdata   <= '0;
        end else begin
            busy      <= (state_next != IDLE);
            mem_rd_en <= (state_next == ACCESS) && !next_we;
            mem_wr_en <= (state_next == ACCESS) && next_we;
            core_done <= go_resp && (resp_owner == OWN_CORE);
            core_err  <= go_resp && (resp_owner == OWN_CORE) && resp_err;
            dma_done  <= go_resp && (resp_owner == OWN_DMA);
            dma_err   <= go_resp && (resp_owner == OWN_DMA) && resp_err;

            if (grant_fire) begin
                owner       <= grant;
                we_q        <= sel_we;
                mem_address <= sel_addr;
                mem_wdata   <= sel_wdata;
                mem_len     <= sel_len;
                cnt         <= 8'd0;
            end

            if (state == ACCESS) begin
                if (mem_ack) begin
                    if (!we_q) begin
                        if (owner == OWN_DMA) begin
                            dma_rdata <= mem_rdata;
                        end else begin
                            core_rdata <= mem_rdata;
                        end
                    end
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        core_req, core_we, core_done, core_err;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [1:0]  core_len;
    logic        dma_req, dma_we, dma_done, dma_err;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [1:0]  dma_len;
    logic        mem_rd_en, mem_wr_en, mem_ack, busy, owner;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [1:0]  mem_len;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata [2];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_len(core_len), .core_rdata(core_rdata),
        .core_done(core_done), .core_err(core_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_len(dma_len), .dma_rdata(dma_rdata),
        .dma_done(dma_done), .dma_err(dma_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_illegal(input logic [1:0] len, input logic [31:0] addr);
        if (len == 2'b11) return 1'b1;
        if (len == 2'b10) return addr % 4 != 0;
        if (len == 2'b01) return addr % 2 != 0;
        return 1'b0;
    endfunction

    task automatic set_fields(input logic own, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [1:0] len);
        if (own) begin
            dma_we = we; dma_addr = addr; dma_wdata = wd; dma_len = len;
        end else begin
            core_we = we; core_addr = addr; core_wdata = wd; core_len = len;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {core_done, core_err, dma_done, dma_err,
                              mem_rd_en, mem_wr_en, busy, owner}, 64'd0);
        check({tag, "_core_rdata"}, core_rdata, 64'd0);
        check({tag, "_dma_rdata"}, dma_rdata, 64'd0);
        check({tag, "_mem_fields"}, {mem_address, mem_wdata}, 64'd0);
        check({tag, "_mem_len"}, mem_len, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; core_req = 1'b0; dma_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
    endtask

    // One transaction from a single requester. ack_k = 0 means memory never
    // acknowledges; otherwise ack arrives in the ack_k-th strobe cycle.
    task automatic do_txn(input string tag, input logic own, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] len, input int ack_k, input logic [31:0] rd);
        bit          ill, timed_out, exp_err, fields_ok, quiet_ok, dir_ok;
        int          exp_str, strobes, done_at;
        logic        got_err, other;
        logic [31:0] got_rd;
        ill       = model_illegal(len, addr);
        timed_out = !ill && (ack_k == 0 || ack_k > TO);
        exp_err   = ill || timed_out;
        exp_str   = ill ? 0 : (timed_out ? TO : ack_k);
        other     = ~own;
        strobes = 0; done_at = -1; got_err = 1'bx; got_rd = 32'hx;
        fields_ok = 1; quiet_ok = 1; dir_ok = 1;

        @(negedge clk);
        set_fields(own, we, addr, wd, len);
        if (own) dma_req = 1'b1; else core_req = 1'b1;
        mem_ack = 1'b0;

        for (int c = 1; c <= TO + 10 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check({tag, "_owner"}, {busy, owner}, {1'b1, own});
                set_fields(own, $urandom_range(0, 1), $urandom, $urandom, 2'($urandom_range(0, 3)));
            end
            if ((other ? dma_done : core_done) !== 1'b0) quiet_ok = 0;
            if ((other ? dma_rdata : core_rdata) !== exp_rdata[other]) quiet_ok = 0;
            if (mem_rd_en || mem_wr_en) begin
                strobes++;
                if (mem_rd_en !== !we || mem_wr_en !== we) dir_ok = 0;
                if (mem_address !== addr || mem_len !== len || mem_wdata !== wd) fields_ok = 0;
                mem_ack   = (strobes == ack_k);
                mem_rdata = (strobes == ack_k) ? rd : $urandom;
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if ((own ? dma_done : core_done) === 1'b1) begin
                done_at = c;
                got_err = own ? dma_err : core_err;
                got_rd  = own ? dma_rdata : core_rdata;
                if (own) dma_req = 1'b0; else core_req = 1'b0;
            end
        end
        mem_ack = 1'b0;
        if (!exp_err && !we) exp_rdata[own] = rd;

        check({tag, "_done_seen"}, done_at >= 0, 1);
        check({tag, "_done_cycle"}, done_at, exp_str + 1);
        check({tag, "_err"}, got_err, exp_err);
        check({tag, "_rdata"}, got_rd, exp_rdata[own]);
        check({tag, "_strobes"}, strobes, exp_str);
        check({tag, "_flags"}, {fields_ok, dir_ok, quiet_ok}, 3'b111);
        @(negedge clk);
        check({tag, "_after"}, {(own ? dma_done : core_done), busy}, 2'b00);
    endtask

    initial begin
        bit          fin;
        int          ng;
        logic        last, expg;
        logic [31:0] a, w;

        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'd0; core_wdata = 32'd0; core_len = 2'b00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0; dma_len = 2'b00;

        do_reset();
        check_all_zero("por");

        // Both requesters held high from reset: strict alternation, core first.
        set_fields(1'b0, 1'b0, 32'h40, 32'd0, 2'b10);
        set_fields(1'b1, 1'b0, 32'h80, 32'd0, 2'b10);
        core_req = 1'b1; dma_req = 1'b1;
        fin = 0; ng = 0; last = 1'b1;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (mem_rd_en || mem_wr_en) begin
                expg = ~last;
                last = expg;
                check($sformatf("rr_grant%0d", ng), owner, expg);
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
                exp_rdata[expg] = mem_rdata;
                ng++;
                if (ng == 6) begin core_req = 1'b0; dma_req = 1'b0; end
            end else begin
                mem_ack = 1'b0;
                if (ng == 6 && !busy) fin = 1;
            end
        end
        mem_ack = 1'b0;
        check("rr_count", ng, 6);
        check("rr_finished", fin, 1);
        check("rr_core_rdata", core_rdata, exp_rdata[0]);
        check("rr_dma_rdata", dma_rdata, exp_rdata[1]);

        do_txn("core_rd",   1'b0, 1'b0, 32'h100, 32'h0,        2'b10, 2, 32'hDEADBEEF);
        do_txn("dma_mis",   1'b1, 1'b1, 32'h203, 32'h12345678, 2'b01, 1, 32'h0);
        do_txn("core_to",   1'b0, 1'b0, 32'h104, 32'h0,        2'b10, 0, 32'h55AA55AA);
        do_txn("core_edge", 1'b0, 1'b0, 32'h108, 32'h0,        2'b10, TO, 32'hCAFEF00D);
        do_txn("dma_byte",  1'b1, 1'b1, 32'h3,   32'hA5A5A5A5, 2'b00, 1, 32'h0);
        do_txn("core_rsvd", 1'b0, 1'b0, 32'h10,  32'h0,        2'b11, 1, 32'h11111111);
        do_txn("dma_late",  1'b1, 1'b0, 32'h20,  32'h0,        2'b01, TO + 1, 32'h22222222);

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            w = $urandom;
            do_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   a, w, 2'($urandom_range(0, 3)), $urandom_range(0, TO + 2), $urandom);
        end

        // Reset in the middle of an access, then a stale ack.
        @(negedge clk);
        set_fields(1'b0, 1'b0, 32'h200, 32'd0, 2'b10);
        core_req = 1'b1;
        @(negedge clk);
        check("midrst_strobe", mem_rd_en, 1);
        @(negedge clk);
        rst = 1'b1; core_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBADBAD01;
        exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0;
        check_all_zero("midrst");
        @(negedge clk);
        mem_ack = 1'b0;
        check_all_zero("stale_ack");
        @(negedge clk);
        check_all_zero("stale_ack2");

        do_txn("dma_after_rst", 1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 1, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
